// File: rtl/mips_alu.sv
// MIPS-style execute-stage integer ALU: one-cycle registered result,
// product high half, branch condition and carry/borrow flags.

package alu_pkg;

  typedef enum logic [4:0] {
    C_ADD_U = 5'd0,
    C_SUB_U = 5'd1,
    C_MULT  = 5'd2,
    C_MUL_U = 5'd3,
    C_AND   = 5'd4,
    C_OR    = 5'd5,
    C_XOR   = 5'd6,
    C_SRL   = 5'd7,
    C_SLL   = 5'd8,
    C_SRA   = 5'd9,
    C_SLT   = 5'd10,
    C_SLTU  = 5'd11,
    C_MFHI  = 5'd12,
    C_MFLO  = 5'd13,
    C_JR    = 5'd14,
    C_BEQ   = 5'd15,
    C_BNE   = 5'd16,
    C_BLEZ  = 5'd17,
    C_BGTZ  = 5'd18,
    C_BLTZ  = 5'd19,
    C_BGEZ  = 5'd20
  } alu_sel_t;

endpackage

module mips_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  alu_sel_t         opsel,
  input  logic [4:0]       ir_shift,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             branch_taken,
  output logic             carry,
  output logic             borrow
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [PW-1:0]    prod_s_c;
  logic [PW-1:0]    prod_u_c;
  logic             shift_big_c;
  logic             a_neg_c;
  logic             a_zero_c;

  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] result_hi_c;
  logic             branch_c;
  logic             carry_c;
  logic             borrow_c;

  // Shared arithmetic: widened sum/difference and sign/zero-extended products.
  always_comb begin
    sum_c       = {1'b0, reg_a} + {1'b0, reg_b};
    diff_c      = {1'b0, reg_a} - {1'b0, reg_b};
    prod_s_c    = PW'($signed({{WIDTH{reg_a[WIDTH-1]}}, reg_a}) *
                      $signed({{WIDTH{reg_b[WIDTH-1]}}, reg_b}));
    prod_u_c    = PW'({{WIDTH{1'b0}}, reg_a} * {{WIDTH{1'b0}}, reg_b});
    shift_big_c = (32'(ir_shift) >= WIDTH);
    a_neg_c     = reg_a[WIDTH-1];
    a_zero_c    = (reg_a == '0);
  end

  // Next-value selection; anything not named for the op stays zero.
  always_comb begin
    result_c    = '0;
    result_hi_c = '0;
    branch_c    = 1'b0;
    carry_c     = 1'b0;
    borrow_c    = 1'b0;
    case (opsel)
      C_ADD_U: begin
        result_c = sum_c[WIDTH-1:0];
        carry_c  = sum_c[WIDTH];
      end
      C_SUB_U: begin
        result_c = diff_c[WIDTH-1:0];
        borrow_c = diff_c[WIDTH];
      end
      C_MULT: begin
        result_c    = prod_s_c[WIDTH-1:0];
        result_hi_c = prod_s_c[PW-1:WIDTH];
      end
      C_MUL_U: begin
        result_c    = prod_u_c[WIDTH-1:0];
        result_hi_c = prod_u_c[PW-1:WIDTH];
      end
      C_AND:   result_c = reg_a & reg_b;
      C_OR:    result_c = reg_a | reg_b;
      C_XOR:   result_c = reg_a ^ reg_b;
      C_SRL:   result_c = shift_big_c ? '0 : (reg_b >> ir_shift);
      C_SLL:   result_c = shift_big_c ? '0 : (reg_b << ir_shift);
      C_SRA:   result_c = shift_big_c ? {WIDTH{reg_b[WIDTH-1]}}
                                      : WIDTH'($signed(reg_b) >>> ir_shift);
      C_SLT:   result_c = WIDTH'($signed(reg_a) < $signed(reg_b));
      C_SLTU:  result_c = WIDTH'(reg_a < reg_b);
      C_BEQ:   branch_c = (reg_a == reg_b);
      C_BNE:   branch_c = (reg_a != reg_b);
      C_BLEZ:  branch_c = a_neg_c | a_zero_c;
      C_BGTZ:  branch_c = ~a_neg_c & ~a_zero_c;
      C_BLTZ:  branch_c = a_neg_c;
      C_BGEZ:  branch_c = ~a_neg_c;
      default: ;
    endcase
  end

  // Output registers; reset clears immediately and drops the op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_hi    <= '0;
      branch_taken <= 1'b0;
      carry        <= 1'b0;
      borrow       <= 1'b0;
    end else begin
      result       <= result_c;
      result_hi    <= result_hi_c;
      branch_taken <= branch_c;
      carry        <= carry_c;
      borrow       <= borrow_c;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu at WIDTH=8: literal spot checks plus a
// randomized sweep checked every cycle against an integer reference model.

module tb_mips_alu;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  alu_sel_t     opsel;
  logic [4:0]   ir_shift;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         branch_taken;
  logic         carry;
  logic         borrow;

  int n_checks = 0;
  int n_fails  = 0;

  mips_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_a        (reg_a),
    .reg_b        (reg_b),
    .opsel        (opsel),
    .ir_shift     (ir_shift),
    .result       (result),
    .result_hi    (result_hi),
    .branch_taken (branch_taken),
    .carry        (carry),
    .borrow       (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on 8-bit values.
  function automatic void model(input int op, input int a, input int b, input int sh,
                                output int r, output int hi, output int br,
                                output int cy, output int bw);
    int sa, sb, p;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; hi = 0; br = 0; cy = 0; bw = 0;
    case (op)
      0:  begin r = (a + b) % 256; cy = (a + b >= 256) ? 1 : 0; end
      1:  begin r = (a - b + 256) % 256; bw = (a < b) ? 1 : 0; end
      2:  begin p = (sa * sb) & 16'hFFFF; r = p % 256; hi = p / 256; end
      3:  begin p = a * b; r = p % 256; hi = p / 256; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (sh >= 8) ? 0 : b / (1 << sh);
      8:  r = (sh >= 8) ? 0 : (b * (1 << sh)) % 256;
      9:  r = (sh >= 8) ? ((sb < 0) ? 255 : 0) : (sb >>> sh) & 255;
      10: r = (sa < sb) ? 1 : 0;
      11: r = (a < b) ? 1 : 0;
      15: br = (a == b) ? 1 : 0;
      16: br = (a != b) ? 1 : 0;
      17: br = (sa <= 0) ? 1 : 0;
      18: br = (sa > 0) ? 1 : 0;
      19: br = (sa < 0) ? 1 : 0;
      20: br = (sa >= 0) ? 1 : 0;
      default: ;
    endcase
  endfunction

  function automatic void check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endfunction

  // Expected outputs captured from the inputs present at each rising edge.
  int  e_r, e_hi, e_br, e_cy, e_bw;
  bit  e_valid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid = 1'b0;
    end else begin
      model(int'(opsel), int'(reg_a), int'(reg_b), int'(ir_shift), e_r, e_hi, e_br, e_cy, e_bw);
      e_valid = 1'b1;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_zero", int'({result, result_hi, branch_taken, carry, borrow}), 0);
    end else if (e_valid) begin
      check("result",       int'(result),       e_r);
      check("result_hi",    int'(result_hi),    e_hi);
      check("branch_taken", int'(branch_taken), e_br);
      check("carry",        int'(carry),        e_cy);
      check("borrow",       int'(borrow),       e_bw);
    end
  end

  task automatic drive(input int op, input int a, input int b, input int sh);
    @(negedge clk);
    opsel    = alu_sel_t'(5'(op));
    reg_a    = W'(a);
    reg_b    = W'(b);
    ir_shift = 5'(sh);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    reg_a    = '0;
    reg_b    = '0;
    opsel    = C_ADD_U;
    ir_shift = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed expectations.
    drive(0, 8'hC8, 8'h64, 0);
    check("add_result", int'(result), 8'h2C);
    check("add_carry",  int'(carry), 1);
    drive(1, 8'h05, 8'h07, 0);
    check("sub_result", int'(result), 8'hFE);
    check("sub_borrow", int'(borrow), 1);
    check("sub_carry",  int'(carry), 0);
    drive(2, 8'hFD, 8'h07, 0);
    check("mult_hi", int'(result_hi), 8'hFF);
    check("mult_lo", int'(result), 8'hEB);
    drive(3, 8'hFD, 8'h07, 0);
    check("mulu_hi", int'(result_hi), 8'h06);
    check("mulu_lo", int'(result), 8'hEB);
    drive(9, 0, 8'h90, 2);  check("sra",     int'(result), 8'hE4);
    drive(7, 0, 8'h90, 2);  check("srl",     int'(result), 8'h24);
    drive(8, 0, 8'h90, 2);  check("sll",     int'(result), 8'h40);
    drive(8, 0, 8'h90, 9);  check("sll_big", int'(result), 8'h00);
    drive(10, 8'h80, 8'h01, 0); check("slt",  int'(result), 1);
    drive(11, 8'h80, 8'h01, 0); check("sltu", int'(result), 0);
    drive(17, 8'h80, 8'h01, 0); check("blez", int'(branch_taken), 1);
    drive(18, 8'h80, 8'h01, 0); check("bgtz", int'(branch_taken), 0);
    drive(19, 8'h80, 8'h01, 0); check("bltz", int'(branch_taken), 1);
    drive(20, 8'h80, 8'h01, 0); check("bgez", int'(branch_taken), 0);
    drive(15, 8'h33, 8'h33, 0); check("beq",  int'(branch_taken), 1);
    drive(16, 8'h33, 8'h33, 0); check("bne",  int'(branch_taken), 0);

    // Sweep a=b=i with random ops and shift amounts.
    for (int i = 0; i < 256; i++)
      drive(int'($urandom_range(0, 31)), i, i, int'($urandom_range(0, 31)));
    // Independent random operands.
    for (int i = 0; i < 400; i++)
      drive(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
    for (int op = 12; op <= 14; op++) begin
      drive(op, 8'hFF, 8'hFF, 3);
      check("hilo_jr_zero", int'({result, result_hi, branch_taken, carry, borrow}), 0);
    end

    // Asynchronous reset mid-stream.
    drive(3, 8'hFD, 8'h07, 0);
    check("pre_reset_hi", int'(result_hi), 8'h06);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", int'({result, result_hi, branch_taken, carry, borrow}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", int'({result, result_hi}), 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("after_release", int'({result, result_hi}), 0);
    @(posedge clk);
    #1;
    check("first_edge_hi", int'(result_hi), 8'h06);
    drive(0, 8'hFF, 8'h01, 0);
    check("add_wrap", int'({carry, result}), 9'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
